// File: rtl/idex_stage.sv
// ID/EX pipeline register with valid bit, stall/flush control, load-use hazard
// detection and a saturating bubble counter for performance monitoring.
module idex_stage #(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 5,
  parameter int CNT_W       = 16,
  parameter int MEMREAD_BIT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_in,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [REG_AW-1:0] id_shamt,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [DATA_W-1:0] id_ext_imm,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [4:0]        ctrl_e,
  input  logic [2:0]        ctrl_m,
  input  logic [1:0]        ctrl_w,
  output logic              ex_valid,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_rd,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_ext_imm,
  output logic [DATA_W-1:0] ex_pc,
  output logic [DATA_W-1:0] ex_shamt,
  output logic              alu_src,
  output logic              reg_dst,
  output logic              jr,
  output logic [1:0]        alu_op,
  output logic [2:0]        ex_m,
  output logic [1:0]        ex_w,
  output logic              load_use_stall,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic [REG_AW-1:0] shamt_r;
  logic [4:0]        ctrl_e_r;
  logic              load_use_s;
  logic              bubble_s;
  logic              cnt_sat_s;

  // Load-use hazard and bubble decision; flush overrides stall, hazard waits for stall to drop
  always_comb begin
    load_use_s = ex_valid & ex_m[MEMREAD_BIT] & id_valid & (ex_rt != {REG_AW{1'b0}}) &
                 ((ex_rt == id_rs) | (ex_rt == id_rt));
    bubble_s   = flush | (~stall_in & load_use_s);
    cnt_sat_s  = (bubble_cnt == {CNT_W{1'b1}});
  end

  assign load_use_stall = load_use_s;
  assign ex_shamt       = {{(DATA_W-REG_AW){1'b0}}, shamt_r};
  assign alu_src        = ctrl_e_r[4];
  assign reg_dst        = ctrl_e_r[3];
  assign jr             = ctrl_e_r[2];
  assign alu_op         = ctrl_e_r[1:0];

  // Pipeline register: a bubble clears only control, leaving address/data fields untouched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid   <= 1'b0;
      ex_rs      <= {REG_AW{1'b0}};
      ex_rt      <= {REG_AW{1'b0}};
      ex_rd      <= {REG_AW{1'b0}};
      shamt_r    <= {REG_AW{1'b0}};
      ex_rd1     <= {DATA_W{1'b0}};
      ex_rd2     <= {DATA_W{1'b0}};
      ex_ext_imm <= {DATA_W{1'b0}};
      ex_pc      <= {DATA_W{1'b0}};
      ctrl_e_r   <= 5'b00000;
      ex_m       <= 3'b000;
      ex_w       <= 2'b00;
      bubble_cnt <= {CNT_W{1'b0}};
    end else if (bubble_s) begin
      ex_valid <= 1'b0;
      ctrl_e_r <= 5'b00000;
      ex_m     <= 3'b000;
      ex_w     <= 2'b00;
      if (!cnt_sat_s) begin
        bubble_cnt <= bubble_cnt + CNT_W'(1'b1);
      end
    end else if (!stall_in) begin
      ex_valid   <= id_valid;
      ex_rs      <= id_rs;
      ex_rt      <= id_rt;
      ex_rd      <= id_rd;
      shamt_r    <= id_shamt;
      ex_rd1     <= id_rd1;
      ex_rd2     <= id_rd2;
      ex_ext_imm <= id_ext_imm;
      ex_pc      <= id_pc;
      ctrl_e_r   <= ctrl_e;
      ex_m       <= ctrl_m;
      ex_w       <= ctrl_w;
    end
  end

endmodule

// File: tb/tb_idex_stage.sv
// Randomized scoreboard bench for idex_stage: a driver pushes expected EX state
// from a reference model, a monitor pops and compares after each rising edge.
module tb_idex_stage;

  localparam int VW = 186;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_in, flush, id_valid;
  logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
  logic [31:0] id_rd1, id_rd2, id_ext_imm, id_pc;
  logic [4:0]  ctrl_e;
  logic [2:0]  ctrl_m;
  logic [1:0]  ctrl_w;

  logic        ex_valid, alu_src, reg_dst, jr, load_use_stall;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [31:0] ex_rd1, ex_rd2, ex_ext_imm, ex_pc, ex_shamt;
  logic [1:0]  alu_op, ex_w;
  logic [2:0]  ex_m;
  logic [15:0] bubble_cnt;

  logic        b_ex_valid, b_alu_src, b_reg_dst, b_jr, b_load_use_stall;
  logic [4:0]  b_ex_rs, b_ex_rt, b_ex_rd;
  logic [31:0] b_ex_rd1, b_ex_rd2, b_ex_ext_imm, b_ex_pc, b_ex_shamt;
  logic [1:0]  b_alu_op, b_ex_w;
  logic [2:0]  b_ex_m;
  logic [1:0]  b_bubble_cnt;

  idex_stage dut (
    .clk(clk), .rst_n(rst_n), .stall_in(stall_in), .flush(flush), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_ext_imm(id_ext_imm), .id_pc(id_pc),
    .ctrl_e(ctrl_e), .ctrl_m(ctrl_m), .ctrl_w(ctrl_w),
    .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_ext_imm(ex_ext_imm), .ex_pc(ex_pc),
    .ex_shamt(ex_shamt), .alu_src(alu_src), .reg_dst(reg_dst), .jr(jr), .alu_op(alu_op),
    .ex_m(ex_m), .ex_w(ex_w), .load_use_stall(load_use_stall), .bubble_cnt(bubble_cnt)
  );

  idex_stage #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .stall_in(stall_in), .flush(flush), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_ext_imm(id_ext_imm), .id_pc(id_pc),
    .ctrl_e(ctrl_e), .ctrl_m(ctrl_m), .ctrl_w(ctrl_w),
    .ex_valid(b_ex_valid), .ex_rs(b_ex_rs), .ex_rt(b_ex_rt), .ex_rd(b_ex_rd),
    .ex_rd1(b_ex_rd1), .ex_rd2(b_ex_rd2), .ex_ext_imm(b_ex_ext_imm), .ex_pc(b_ex_pc),
    .ex_shamt(b_ex_shamt), .alu_src(b_alu_src), .reg_dst(b_reg_dst), .jr(b_jr),
    .alu_op(b_alu_op), .ex_m(b_ex_m), .ex_w(b_ex_w), .load_use_stall(b_load_use_stall),
    .bubble_cnt(b_bubble_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs, rt, rd, sh;
    logic [31:0] rd1, rd2, imm, pc;
    logic [4:0]  ce;
    logic [2:0]  m;
    logic [1:0]  w;
  } st_t;

  typedef struct {
    logic           hz;
    logic [VW-1:0]  vec;
    int unsigned    cnt;
  } exp_t;

  st_t         mdl;
  int unsigned mcnt;
  exp_t        q[$];
  int          passed = 0;
  int          total  = 0;
  logic        hz_smp;

  wire [VW-1:0] vec_a = {ex_valid, ex_rs, ex_rt, ex_rd, ex_rd1, ex_rd2, ex_ext_imm, ex_pc,
                         ex_shamt, alu_src, reg_dst, jr, alu_op, ex_m, ex_w};
  wire [VW-1:0] vec_b = {b_ex_valid, b_ex_rs, b_ex_rt, b_ex_rd, b_ex_rd1, b_ex_rd2,
                         b_ex_ext_imm, b_ex_pc, b_ex_shamt, b_alu_src, b_reg_dst, b_jr,
                         b_alu_op, b_ex_m, b_ex_w};

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [VW-1:0] pk(input st_t s);
    return {s.valid, s.rs, s.rt, s.rd, s.rd1, s.rd2, s.imm, s.pc, 27'd0, s.sh,
            s.ce, s.m, s.w};
  endfunction

  // Reference: hazard from the spec formula, then flush > stall > hazard > load
  task automatic step();
    exp_t e;
    logic hz;
    hz = mdl.valid && mdl.m[1] && id_valid && (mdl.rt != 5'd0) &&
         ((mdl.rt == id_rs) || (mdl.rt == id_rt));
    if (flush || (!stall_in && hz)) begin
      mdl.valid = 1'b0; mdl.ce = 5'd0; mdl.m = 3'd0; mdl.w = 2'd0;
      mcnt++;
    end else if (!stall_in) begin
      mdl.valid = id_valid; mdl.rs = id_rs; mdl.rt = id_rt; mdl.rd = id_rd;
      mdl.sh = id_shamt; mdl.rd1 = id_rd1; mdl.rd2 = id_rd2; mdl.imm = id_ext_imm;
      mdl.pc = id_pc; mdl.ce = ctrl_e; mdl.m = ctrl_m; mdl.w = ctrl_w;
    end
    e.hz = hz; e.vec = pk(mdl); e.cnt = mcnt;
    q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rand_in();
    id_valid   = ($urandom_range(0, 3) != 0);
    id_rs      = 5'($urandom_range(0, 3));
    id_rt      = 5'($urandom_range(0, 3));
    id_rd      = 5'($urandom);
    id_shamt   = 5'($urandom);
    id_rd1     = $urandom;
    id_rd2     = $urandom;
    id_ext_imm = $urandom;
    id_pc      = $urandom;
    ctrl_e     = 5'($urandom);
    ctrl_m     = 3'($urandom);
    ctrl_w     = 2'($urandom);
    flush      = ($urandom_range(0, 9) == 0);
    stall_in   = ($urandom_range(0, 5) == 0);
  endtask

  // Monitor: hazard sampled mid low phase, registered state just after the edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3 hz_smp = load_use_stall;
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("load_use_stall", VW'(hz_smp), VW'(e.hz));
        chk("ex_state", vec_a, e.vec);
        chk("ex_state_cnt2", vec_b, e.vec);
        chk("bubble_cnt", VW'(bubble_cnt), VW'((e.cnt > 65535) ? 65535 : e.cnt));
        chk("bubble_cnt_sat", VW'(b_bubble_cnt), VW'((e.cnt > 3) ? 3 : e.cnt));
      end
    end
  end

  initial begin
    stall_in = 1'b0; flush = 1'b0; id_valid = 1'b0;
    id_rs = 5'd0; id_rt = 5'd0; id_rd = 5'd0; id_shamt = 5'd0;
    id_rd1 = 32'd0; id_rd2 = 32'd0; id_ext_imm = 32'd0; id_pc = 32'd0;
    ctrl_e = 5'd0; ctrl_m = 3'd0; ctrl_w = 2'd0;
    mdl = '0; mcnt = 0;
    repeat (2) @(negedge clk);
    chk("reset_state", vec_a, '0);
    chk("reset_cnt", VW'(bubble_cnt), '0);
    rst_n = 1'b1;

    // plain load of a jr-style instruction
    id_valid = 1'b1; id_pc = 32'h40; ctrl_e = 5'b10110; id_shamt = 5'd7;
    id_rs = 5'd1; id_rt = 5'd2; id_rd = 5'd3; id_rd1 = 32'h11; id_rd2 = 32'h22;
    id_ext_imm = 32'hffff_fff0; ctrl_m = 3'b000; ctrl_w = 2'b10;
    step();

    // load in EX writing r8, dependent use of r8 next
    ctrl_e = 5'b10000; ctrl_m = 3'b010; id_rt = 5'd8; id_rs = 5'd4;
    step();
    ctrl_m = 3'b000; id_rs = 5'd8; id_rt = 5'd9;
    step();
    step();

    // load targeting r0 never triggers a hazard
    ctrl_m = 3'b010; id_rt = 5'd0; id_rs = 5'd5;
    step();
    ctrl_m = 3'b000; id_rs = 5'd0; id_rt = 5'd0;
    step();

    // stall holds with changing inputs, flush still wins during stall
    repeat (3) begin
      rand_in();
      flush = 1'b0; stall_in = 1'b1;
      step();
    end
    flush = 1'b1;
    step();
    flush = 1'b0; stall_in = 1'b0;

    repeat (400) begin
      rand_in();
      step();
    end

    // async reset between edges while ex_valid is high
    rand_in();
    flush = 1'b0; stall_in = 1'b0; id_valid = 1'b1; id_rs = 5'd0; id_rt = 5'd0;
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_state", vec_a, '0);
    chk("async_reset_cnt", VW'(bubble_cnt), '0);
    mdl = '0; mcnt = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // five flushes from zero: narrow counter reads 1,2,3,3,3
    flush = 1'b1;
    repeat (5) step();
    flush = 1'b0;

    repeat (100) begin
      rand_in();
      step();
    end

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() > 0) begin
      total++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
